// File: rtl/lif_neuron_core.sv
// Leaky integrate-and-fire neuron: 8-bit membrane with multiplicative leak, a saturating
// spike counter and a fixed refractory hold, frozen while the parameter loader shifts.
module lif_neuron_core #(
    parameter int REFRACT_CYCLES = 4,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_busy,
    input  logic [7:0]             tau,
    input  logic [7:0]             weight,
    input  logic [7:0]             threshold,
    input  logic                   spike_in,
    output logic [7:0]             potential,
    output logic                   spike_out,
    output logic                   refractory,
    output logic [COUNT_WIDTH-1:0] spike_count
);

    localparam int REF_W = (REFRACT_CYCLES > 1) ? $clog2(REFRACT_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_INTEGRATE,
        ST_REFRACT,
        ST_FROZEN,
        ST_LOAD
    } state_t;

    state_t     state, state_n;
    logic [REF_W-1:0] ref_cnt;
    logic [7:0] tau_q, weight_q, threshold_q;
    logic       cfg_busy_q;
    logic [7:0] leak, v_leaked, v_next;
    logic [8:0] v_sum;
    logic       fire;

    function automatic logic [7:0] sat_u8(input logic [8:0] x);
        return x[8] ? 8'hFF : x[7:0];
    endfunction

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] x);
        return (&x) ? x : x + 1'b1;
    endfunction

    // Leak truncates toward zero, so a potential of 1 never decays away.
    always_comb begin
        leak     = 8'((16'(potential) * 16'(tau_q)) >> 8);
        v_leaked = potential - leak;
        v_sum    = {1'b0, v_leaked} + (spike_in ? {1'b0, weight_q} : 9'd0);
        v_next   = sat_u8(v_sum);
        fire     = (threshold_q != 8'd0) && (v_next >= threshold_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_INTEGRATE;
            cfg_busy_q <= 1'b0;
        end else begin
            state      <= state_n;
            cfg_busy_q <= cfg_busy;
        end
    end

    always_comb begin
        state_n = state;
        if (cfg_busy) begin
            state_n = ST_FROZEN;
        end else begin
            case (state)
                ST_INTEGRATE: if (fire && REFRACT_CYCLES > 0) state_n = ST_REFRACT;
                ST_REFRACT:   if (ref_cnt == '0) state_n = ST_INTEGRATE;
                ST_FROZEN:    if (cfg_busy_q) state_n = ST_LOAD;
                ST_LOAD:      state_n = ST_INTEGRATE;
                default:      state_n = ST_INTEGRATE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            potential   <= 8'd0;
            spike_out   <= 1'b0;
            spike_count <= '0;
            ref_cnt     <= '0;
            tau_q       <= 8'd0;
            weight_q    <= 8'd0;
            threshold_q <= 8'd0;
        end else if (cfg_busy) begin
            spike_out <= 1'b0;
            ref_cnt   <= '0;
        end else begin
            case (state)
                ST_INTEGRATE: begin
                    if (fire) begin
                        potential   <= 8'd0;
                        spike_out   <= 1'b1;
                        spike_count <= sat_inc(spike_count);
                        if (REFRACT_CYCLES > 0) ref_cnt <= REF_W'(REFRACT_CYCLES - 1);
                    end else begin
                        potential <= v_next;
                        spike_out <= 1'b0;
                    end
                end
                ST_REFRACT: begin
                    potential <= 8'd0;
                    spike_out <= 1'b0;
                    if (ref_cnt != '0) ref_cnt <= ref_cnt - 1'b1;
                end
                ST_LOAD: begin
                    tau_q       <= tau;
                    weight_q    <= weight;
                    threshold_q <= threshold;
                    potential   <= 8'd0;
                    spike_out   <= 1'b0;
                end
                default: spike_out <= 1'b0;
            endcase
        end
    end

    assign refractory = (state == ST_REFRACT);

endmodule

// File: tb/tb_lif_neuron_core.sv
// Scoreboarded bench for lif_neuron_core: directed scenarios plus randomized traffic,
// each edge's expected outputs come from a plain-integer neuron model.
module tb_lif_neuron_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_busy = 1'b0;
    logic [7:0]  tau = 8'd0, weight = 8'd0, threshold = 8'd0;
    logic        spike_in = 1'b0;
    logic [7:0]  potential;
    logic        spike_out, refractory;
    logic [15:0] spike_count;

    always #5 clk = ~clk;

    lif_neuron_core #(.REFRACT_CYCLES(4), .COUNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .cfg_busy(cfg_busy), .tau(tau), .weight(weight),
        .threshold(threshold), .spike_in(spike_in), .potential(potential),
        .spike_out(spike_out), .refractory(refractory), .spike_count(spike_count)
    );

    typedef struct {
        int pot;
        int spk;
        int refr;
        int cnt;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_fail   = 0;

    // Reference neuron in plain integers.
    int m_pot = 0, m_spk = 0, m_cnt = 0, m_ref_left = 0;
    int m_frozen = 0, m_load_pending = 0;
    int m_tau = 0, m_w = 0, m_thr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_edge(input int r, input int b, input int t, input int w,
                              input int th, input int s);
        int leak, vn;
        if (r != 0) begin
            m_pot = 0; m_spk = 0; m_cnt = 0; m_ref_left = 0;
            m_frozen = 0; m_load_pending = 0;
            m_tau = 0; m_w = 0; m_thr = 0;
        end else if (b != 0) begin
            m_frozen = 1; m_load_pending = 0; m_spk = 0; m_ref_left = 0;
        end else if (m_frozen != 0) begin
            m_frozen = 0; m_load_pending = 1; m_spk = 0;
        end else if (m_load_pending != 0) begin
            m_load_pending = 0;
            m_tau = t; m_w = w; m_thr = th;
            m_pot = 0; m_spk = 0;
        end else if (m_ref_left > 0) begin
            m_ref_left--; m_pot = 0; m_spk = 0;
        end else begin
            leak = (m_pot * m_tau) / 256;
            vn = m_pot - leak + ((s != 0) ? m_w : 0);
            if (vn > 255) vn = 255;
            if (m_thr != 0 && vn >= m_thr) begin
                m_pot = 0; m_spk = 1; m_ref_left = 4;
                if (m_cnt < 65535) m_cnt++;
            end else begin
                m_pot = vn; m_spk = 0;
            end
        end
    endtask

    task automatic step(input int r, input int b, input int t, input int w,
                        input int th, input int s);
        exp_t e;
        @(negedge clk);
        rst = (r != 0); cfg_busy = (b != 0);
        tau = 8'(t); weight = 8'(w); threshold = 8'(th); spike_in = (s != 0);
        model_edge(r, b, t, w, th, s);
        e.pot = m_pot; e.spk = m_spk; e.refr = (m_ref_left > 0) ? 1 : 0; e.cnt = m_cnt;
        sb.push_back(e);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int t, input int w, input int th);
        step(0, 1, t, w, th, 0);
        step(0, 0, t, w, th, 0);
        step(0, 0, t, w, th, 0);
    endtask

    // Monitor: every edge with a pending expectation is compared.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("potential", 32'(potential), 32'(e.pot));
                chk("spike_out", 32'(spike_out), 32'(e.spk));
                chk("refractory", 32'(refractory), 32'(e.refr));
                chk("spike_count", 32'(spike_count), 32'(e.cnt));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t3[10] = '{100, 50, 25, 13, 7, 4, 2, 1, 1, 1};

        // Unconfigured after reset: no integration, no firing
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 1);
        after_edge();
        chk("t1_count", 32'(spike_count), 32'd0);
        chk("t1_pot", 32'(potential), 32'd0);

        // Load and fire twice with a 4-cycle refractory gap
        for (int i = 0; i < 3; i++) step(0, 1, 0, 10, 30, 0);
        for (int i = 0; i < 16; i++) step(0, 0, 0, 10, 30, 1);
        after_edge();
        chk("t2_count", 32'(spike_count), 32'd2);

        // Leak sequence with floor at 1
        load(128, 100, 255);
        step(0, 0, 128, 100, 255, 1);
        after_edge();
        chk("t3_pot0", 32'(potential), 32'(t3[0]));
        for (int i = 1; i < 10; i++) begin
            step(0, 0, 128, 100, 255, 0);
            after_edge();
            chk("t3_pot", 32'(potential), 32'(t3[i]));
        end

        // Saturation at 255 still fires
        load(0, 200, 255);
        step(0, 0, 0, 200, 255, 1);
        after_edge();
        chk("t4_pot200", 32'(potential), 32'd200);
        step(0, 0, 0, 200, 255, 1);
        after_edge();
        chk("t4_fire", 32'(spike_out), 32'd1);
        chk("t4_pot0", 32'(potential), 32'd0);

        // Freeze mid-integration, then adopt new weight
        load(0, 10, 200);
        step(0, 0, 0, 10, 200, 1);
        step(0, 0, 0, 10, 200, 1);
        after_edge();
        chk("t5_pot20", 32'(potential), 32'd20);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 5, 200, 1);
            after_edge();
            chk("t5_hold", 32'(potential), 32'd20);
        end
        step(0, 0, 0, 5, 200, 1);
        after_edge();
        chk("t5_edgeA", 32'(potential), 32'd20);
        step(0, 0, 0, 5, 200, 1);
        after_edge();
        chk("t5_edgeB", 32'(potential), 32'd0);
        step(0, 0, 0, 5, 200, 1);
        after_edge();
        chk("t5_newW", 32'(potential), 32'd5);

        // Reset during refractory clears everything
        load(0, 50, 100);
        step(0, 0, 0, 50, 100, 1);
        step(0, 0, 0, 50, 100, 1);
        after_edge();
        chk("t6_fire", 32'(spike_out), 32'd1);
        step(0, 0, 0, 50, 100, 1);
        after_edge();
        chk("t6_refr", 32'(refractory), 32'd1);
        step(1, 0, 0, 50, 100, 1);
        after_edge();
        chk("t6_rst_refr", 32'(refractory), 32'd0);
        chk("t6_rst_count", 32'(spike_count), 32'd0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 50, 100, 1);
        after_edge();
        chk("t6_nofire", 32'(spike_count), 32'd0);
        chk("t6_pot", 32'(potential), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            int r, b;
            r = ($urandom_range(0, 199) == 0) ? 1 : 0;
            b = ($urandom_range(0, 15) == 0) ? 1 : 0;
            step(r, b, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 255)), int'($urandom_range(0, 1)));
        end
        after_edge();
        after_edge();
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
